gnr_attractor_ctrl: RTL and testbench

- Control stage directly upstream of the per-node GRN state blocks (two-copy Boolean nodes with reset_nos/start_s0/start_s1 inputs).
- Sweeps a range of initial network states. For each one it loads the nodes, steps them in tortoise/hare fashion, and detects the attractor by comparing the s0 and s1 state vectors.
- Each result is reported through a valid/ready handshake to the downstream result collector.

---
 rtl/gnr_attractor_ctrl.sv | 152 +++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - attractor sweep controller for two-copy GRN node blocks
//
// Purpose: sweeps initial states init_first..init_last. For each one it loads
// the nodes, steps them tortoise/hare style and reports the step count at
// which s0 == s1 (checked on even counts only) or a timeout at MAX_STEPS.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start                  sweep start pulse (honoured in IDLE only)
//   init_first, init_last  inclusive sweep range, latched on start
//   s0_vec, s1_vec         tortoise / hare node state vectors
//   reset_nos, init_state  node load strobe and load value
//   start_s0, start_s1     node step strobes
//   busy, done             run status, end-of-sweep pulse
//   res_valid/res_ready    result handshake; res_init/res_steps/res_timeout payload
module gnr_attractor_ctrl #(
  parameter int unsigned           N_NODES   = 8,
  parameter int unsigned           CNT_W     = 16,
  parameter logic [CNT_W-1:0]      MAX_STEPS = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_first,
  input  logic [N_NODES-1:0] init_last,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [CNT_W-1:0]   res_steps,
  output logic               res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_CHECK,
    S_REPORT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N_NODES-1:0] cur_init_q, cur_init_d;
  logic [N_NODES-1:0] last_q, last_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [N_NODES-1:0] res_init_q, res_init_d;
  logic [CNT_W-1:0]   res_steps_q, res_steps_d;
  logic               res_timeout_q, res_timeout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cur_init_q    <= '0;
      last_q        <= '0;
      k_q           <= '0;
      res_init_q    <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_init_q    <= cur_init_d;
      last_q        <= last_d;
      k_q           <= k_d;
      res_init_q    <= res_init_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_init_d    = cur_init_q;
    last_d        = last_q;
    k_d           = k_q;
    res_init_d    = res_init_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_init_d = init_first;
          last_d     = init_last;
          state_d    = (init_last < init_first) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        k_d     = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        // k counts hare steps; it is already updated when CHECK looks at it.
        k_d     = (k_q == MAX_STEPS) ? k_q : k_q + 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Tortoise has taken k/2 steps only when k is even, so odd k is never compared.
        if (!k_q[0] && (s0_vec == s1_vec)) begin
          res_init_d    = cur_init_q;
          res_steps_d   = k_q;
          res_timeout_d = 1'b0;
          state_d       = S_REPORT;
        end else if (k_q == MAX_STEPS) begin
          res_init_d    = cur_init_q;
          res_steps_d   = k_q;
          res_timeout_d = 1'b1;
          state_d       = S_REPORT;
        end else begin
          state_d = S_STEP;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          // Test for the last state before incrementing so an all-ones range end cannot wrap.
          if (cur_init_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cur_init_d = cur_init_q + 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign reset_nos   = (state_q == S_LOAD);
  assign start_s0    = (state_q == S_STEP);
  assign start_s1    = (state_q == S_STEP);
  assign busy        = (state_q == S_LOAD) || (state_q == S_STEP) ||
                       (state_q == S_CHECK) || (state_q == S_REPORT);
  assign done        = (state_q == S_DONE);
  assign res_valid   = (state_q == S_REPORT);
  assign init_state  = cur_init_q;
  assign res_init    = res_init_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - randomized self-checking bench for gnr_attractor_ctrl
module tb_gnr_attractor_ctrl;

  localparam int          MAXS  = 10;
  localparam logic [15:0] MAX_S = 16'd10;

  typedef struct {
    logic [7:0]  init;
    logic [15:0] steps;
    logic        to;
  } rep_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  init_first = '0;
  logic [7:0]  init_last = '0;
  logic [7:0]  s0_vec, s1_vec;
  logic        reset_nos, start_s0, start_s1, busy, done, res_valid, res_timeout;
  logic        res_ready;
  logic [7:0]  init_state, res_init;
  logic [15:0] res_steps;

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [7:0]  tbl [256];
  rep_t        exp_q [$];
  int          ndone = 0, nrep = 0, nload = 0;
  int          n0, r0;
  int          rdy_mode = 1;
  logic        manual_ready = 1'b0;
  logic        rnd_ready = 1'b1;
  rep_t        last_rep;

  gnr_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(MAX_S)) dut (
    .clk(clk), .rst(rst), .start(start), .init_first(init_first), .init_last(init_last),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .res_init(res_init),
    .res_steps(res_steps), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  assign res_ready = (rdy_mode == 0) ? manual_ready : (rdy_mode == 1) ? 1'b1 : rnd_ready;

  always @(posedge clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  // Network update function for the current scenario.
  function automatic logic [7:0] f(input logic [7:0] x);
    case (mode)
      0:       return 8'h3C;
      1:       return ~x;
      2:       return x + 8'd1;
      default: return tbl[x];
    endcase
  endfunction

  function automatic logic [7:0] iter(input logic [7:0] x, input int n);
    logic [7:0] v = x;
    for (int i = 0; i < n; i++) v = f(v);
    return v;
  endfunction

  // Reference result for one initial state: smallest even k with F^(k/2)(x) == F^k(x).
  function automatic rep_t exp_run(input logic [7:0] x);
    rep_t r;
    r.init = x;
    for (int k = 1; k <= MAXS; k++) begin
      if ((k % 2 == 0) && (iter(x, k / 2) == iter(x, k))) begin
        r.steps = 16'(k);
        r.to    = 1'b0;
        return r;
      end
    end
    r.steps = MAX_S;
    r.to    = 1'b1;
    return r;
  endfunction

  // Two-copy node array: s1 advances every step, s0 on every second one.
  logic tog;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vec <= '0; s1_vec <= '0; tog <= 1'b0;
    end else if (reset_nos) begin
      s0_vec <= init_state; s1_vec <= init_state; tog <= 1'b0;
    end else if (start_s1) begin
      s1_vec <= f(s1_vec);
      if (start_s0 && !tog) s0_vec <= f(s0_vec);
      tog <= ~tog;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle monitor.
  logic        pv = 1'b0;
  rep_t        prev;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (reset_nos || start_s0 || start_s1)
        chk("strobe_excl", {31'd0, reset_nos && (start_s0 || start_s1)}, 0);
      if (reset_nos) begin
        nload++;
        if (exp_q.size() > 0) chk("load_init", init_state, exp_q[0].init);
        else chk("unexpected_load", 1, 0);
      end
      if (res_valid) begin
        chk("strobe_in_report", {31'd0, reset_nos | start_s0 | start_s1}, 0);
        if (pv) begin
          chk("hold_init", res_init, prev.init);
          chk("hold_steps", res_steps, prev.steps);
          chk("hold_to", res_timeout, prev.to);
        end
        if (res_ready) begin
          nrep++;
          last_rep.init = res_init; last_rep.steps = res_steps; last_rep.to = res_timeout;
          if (exp_q.size() == 0) begin
            chk("unexpected_report", 1, 0);
          end else begin
            chk("res_init", res_init, exp_q[0].init);
            chk("res_steps", res_steps, exp_q[0].steps);
            chk("res_timeout", res_timeout, exp_q[0].to);
            void'(exp_q.pop_front());
          end
          pv = 1'b0;
        end else begin
          pv = 1'b1;
          prev.init = res_init; prev.steps = res_steps; prev.to = res_timeout;
        end
      end else begin
        pv = 1'b0;
      end
      if (done) ndone++;
    end
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    n0 = ndone; r0 = nrep;
    if (b >= a) for (int x = a; x <= b; x++) exp_q.push_back(exp_run(8'(x)));
    @(posedge clk); #1;
    init_first = a; init_last = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish(input int expn);
    bit seen = 0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("done_seen", {31'd0, seen}, 1);
    @(posedge clk); #1;
    chk("done_count", ndone - n0, 1);
    chk("report_count", nrep - r0, expn);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after", {31'd0, busy}, 0);
    exp_q.delete();
  endtask

  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input int rm);
    rdy_mode = rm;
    launch(a, b);
    finish((b >= a) ? int'(b) - int'(a) + 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    bit got;
    foreach (tbl[i]) tbl[i] = 8'($urandom_range(0, 15));
    #1;
    chk("rst_reset_nos", {31'd0, reset_nos}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_init_state", init_state, 0);
    chk("rst_res_steps", res_steps, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Fixed point, single state.
    mode = 0; l0 = nload;
    run_sweep(8'h05, 8'h05, 1);
    chk("fp_loads", nload - l0, 1);
    chk("fp_lit_steps", last_rep.steps, 16'd2);
    chk("fp_lit_to", {31'd0, last_rep.to}, 0);
    chk("fp_lit_init", last_rep.init, 8'h05);

    // Oscillator, four states.
    mode = 1; l0 = nload;
    run_sweep(8'h00, 8'h03, 1);
    chk("osc_loads", nload - l0, 4);

    // Non-converging: timeout at MAX_STEPS.
    mode = 2;
    run_sweep(8'h07, 8'h07, 1);
    chk("nc_lit_steps", last_rep.steps, 16'd10);
    chk("nc_lit_to", {31'd0, last_rep.to}, 1);

    // Backpressure for five cycles.
    mode = 0; rdy_mode = 0; manual_ready = 1'b0;
    launch(8'h21, 8'h21);
    got = 0;
    for (int c = 0; c < 100; c++) begin
      if (res_valid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", {31'd0, got}, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, res_valid}, 1);
    end
    manual_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", {31'd0, res_valid}, 0);
    finish(1);
    manual_ready = 1'b0;

    // Range edges.
    run_sweep(8'hFF, 8'hFF, 1);
    run_sweep(8'h04, 8'h02, 1);

    // Start while busy is ignored.
    rdy_mode = 1;
    launch(8'h10, 8'h11);
    repeat (3) @(posedge clk);
    #1 init_first = 8'h40; init_last = 8'h40; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish(2);

    // Asynchronous reset mid-STEP.
    launch(8'h30, 8'h32);
    got = 0;
    for (int c = 0; c < 100; c++) begin
      if (start_s0) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("ar_step_seen", {31'd0, got}, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_start_s0", {31'd0, start_s0}, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_init_state", init_state, 0);
    chk("ar_res_valid", {31'd0, res_valid}, 0);
    chk("ar_res_steps", res_steps, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    run_sweep(8'h30, 8'h30, 1);

    // Randomized networks, ranges and backpressure.
    mode = 3;
    for (int t = 0; t < 8; t++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 250));
      b = a + 8'($urandom_range(0, 4));
      run_sweep(a, b, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
